// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and the memory arbiter source id.
package core_pkg;

   localparam int Xlen     = 64;
   localparam int MaskBits = 8;

   // Source of a memory request; stored in the arbiter's response tracker.
   typedef enum logic [0:0] {
      ArbSrcInst = 1'b0,
      ArbSrcData = 1'b1
   } arb_src_e;

endpackage : core_pkg

// File: rtl/fifo.sv
// Synchronous FIFO with a registered full flag.
// Write side: wr_ready_o is the inverted registered full flag. A push happens when
// wr_valid_i && wr_ready_o. Read side: a pop happens when rd_valid_o && rd_ready_i.
// A push and a pop in the same cycle both take effect.
module fifo #(
   parameter int DepthLog2 = 2,
   parameter int Width     = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic [Width-1:0] wr_data_i,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [Width-1:0] rd_data_o
);

   localparam int Depth = 1 << DepthLog2;

   logic [Width-1:0]     mem_q [Depth];
   logic [Width-1:0]     mem_d [Depth];
   logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DepthLog2:0]   count_q, count_d;
   logic                 full_q, full_d;
   logic                 push, pop;

   assign wr_ready_o = !full_q;
   assign rd_valid_o = (count_q != '0);
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign push       = wr_valid_i && !full_q;
   assign pop        = rd_ready_i && rd_valid_o;

   // Next-state for storage, pointers, occupancy and the full flag.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      full_d = (count_d == (DepthLog2 + 1)'(Depth));
   end

   // State registers; reset empties the FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
      mem_q <= mem_d;
   end

endmodule : fifo

// File: rtl/mem_arbiter.sv
// Merges the instruction-fetch and data (LSU) ports onto one memory port and
// routes in-order responses back to the requesting port.
// Build option: MEM_ARBITER_RR_EN selects round-robin on contention instead of
// fixed data-over-inst priority.
// Handshake: a request transfers when mem_valid_o && mem_ready_i; the granted
// port's *_ready_o mirrors that condition. No valid depends on any ready.
module mem_arbiter
   import core_pkg::*;
#(
   parameter int DepthLog2 = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,

   input  logic                inst_valid_i,
   output logic                inst_ready_o,
   input  logic [Xlen-1:0]     inst_addr_i,
   input  logic [Xlen-1:0]     inst_wdata_i,
   input  logic [MaskBits-1:0] inst_wmask_i,
   output logic [Xlen-1:0]     inst_rdata_o,
   output logic                inst_rvalid_o,

   input  logic                data_valid_i,
   output logic                data_ready_o,
   input  logic [Xlen-1:0]     data_addr_i,
   input  logic [Xlen-1:0]     data_wdata_i,
   input  logic [MaskBits-1:0] data_wmask_i,
   output logic [Xlen-1:0]     data_rdata_o,
   output logic                data_rvalid_o,

   input  logic                mem_ready_i,
   output logic                mem_valid_o,
   output logic [Xlen-1:0]     mem_addr_o,
   output logic [Xlen-1:0]     mem_wdata_o,
   output logic [MaskBits-1:0] mem_wmask_o,
   input  logic [Xlen-1:0]     mem_rdata_i,
   input  logic                mem_rvalid_i
);

   logic     prefer_data;
   logic     grant_data;
   logic     grant_inst;
   logic     req_hs;
   logic     trk_full;
   logic     trk_wr_ready;
   logic     trk_rd_valid;
   logic     trk_rd_data;
   arb_src_e grant_src;
   arb_src_e head_src;

`ifdef MEM_ARBITER_RR_EN
   arb_src_e last_q, last_d;

   // Contention goes to the port that did not win the last handshake.
   assign prefer_data = (last_q == ArbSrcInst);

   // Last-grant register moves only when a request actually transfers.
   always_comb begin
      last_d = last_q;
      if (req_hs) begin
         last_d = grant_src;
      end
   end

   // Last-grant register; reset points at inst so data wins the first contention.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= ArbSrcInst;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign prefer_data = 1'b1;
`endif

   // Grant, request mux, handshakes and response routing.
   always_comb begin
      grant_data = data_valid_i && (!inst_valid_i || prefer_data);
      grant_inst = inst_valid_i && !grant_data;
      grant_src  = grant_inst ? ArbSrcInst : ArbSrcData;

      mem_valid_o = (grant_data || grant_inst) && !trk_full && !rst_i;
      mem_addr_o  = grant_inst ? inst_addr_i  : data_addr_i;
      mem_wdata_o = grant_inst ? inst_wdata_i : data_wdata_i;
      mem_wmask_o = grant_inst ? inst_wmask_i : data_wmask_i;

      inst_ready_o = grant_inst && mem_ready_i && !trk_full && !rst_i;
      data_ready_o = grant_data && mem_ready_i && !trk_full && !rst_i;
      req_hs       = mem_valid_o && mem_ready_i;

      head_src      = arb_src_e'(trk_rd_data);
      inst_rvalid_o = mem_rvalid_i && trk_rd_valid && (head_src == ArbSrcInst) && !rst_i;
      data_rvalid_o = mem_rvalid_i && trk_rd_valid && (head_src == ArbSrcData) && !rst_i;
      inst_rdata_o  = mem_rdata_i;
      data_rdata_o  = mem_rdata_i;
   end

   assign trk_full = !trk_wr_ready;

   // Outstanding-request tracker holding the source id of each accepted request.
   fifo #(
      .DepthLog2 (DepthLog2),
      .Width     (1)
   ) u_tracker (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_valid_i (req_hs),
      .wr_ready_o (trk_wr_ready),
      .wr_data_i  (grant_src),
      .rd_valid_o (trk_rd_valid),
      .rd_ready_i (mem_rvalid_i),
      .rd_data_o  (trk_rd_data)
   );

   // A response with nothing outstanding is dropped; flag it in simulation.
   always_ff @(posedge clk_i) begin
      if (!rst_i && mem_rvalid_i) begin
         assert (trk_rd_valid)
         else $warning("mem_arbiter: response with no outstanding request dropped");
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Drives inputs 1 time unit after each rising
// edge and samples combinational outputs 1 unit later, well before the next edge.
// Round-robin expectations apply when MEM_ARBITER_RR_EN is defined.
module tb_mem_arbiter;
   import core_pkg::*;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                inst_valid_i, inst_ready_o, inst_rvalid_o;
   logic [Xlen-1:0]     inst_addr_i, inst_wdata_i, inst_rdata_o;
   logic [MaskBits-1:0] inst_wmask_i;
   logic                data_valid_i, data_ready_o, data_rvalid_o;
   logic [Xlen-1:0]     data_addr_i, data_wdata_i, data_rdata_o;
   logic [MaskBits-1:0] data_wmask_i;
   logic                mem_ready_i, mem_valid_o, mem_rvalid_i;
   logic [Xlen-1:0]     mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [MaskBits-1:0] mem_wmask_o;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter #(.DepthLog2(2)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .inst_valid_i  (inst_valid_i),
      .inst_ready_o  (inst_ready_o),
      .inst_addr_i   (inst_addr_i),
      .inst_wdata_i  (inst_wdata_i),
      .inst_wmask_i  (inst_wmask_i),
      .inst_rdata_o  (inst_rdata_o),
      .inst_rvalid_o (inst_rvalid_o),
      .data_valid_i  (data_valid_i),
      .data_ready_o  (data_ready_o),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_wmask_i  (data_wmask_i),
      .data_rdata_o  (data_rdata_o),
      .data_rvalid_o (data_rvalid_o),
      .mem_ready_i   (mem_ready_i),
      .mem_valid_o   (mem_valid_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_wmask_o   (mem_wmask_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_rvalid_i  (mem_rvalid_i)
   );

   // Clock: 10 time-unit period.
   always #5 clk_i = ~clk_i;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Let combinational outputs settle after input changes.
   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic exp_data;
   logic prev_data;

   initial begin
      // ---------------- reset: outputs gated even with active inputs
      rst_i        = 1'b1;
      inst_valid_i = 1'b1;
      inst_addr_i  = '0;
      inst_wdata_i = '0;
      inst_wmask_i = '0;
      data_valid_i = 1'b0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      data_wmask_i = '0;
      mem_ready_i  = 1'b1;
      mem_rdata_i  = '0;
      mem_rvalid_i = 1'b1;
      tick();
      tick();
      chk("rst_inst_ready", inst_ready_o, 1'b0);
      chk("rst_data_ready", data_ready_o, 1'b0);
      chk("rst_mem_valid", mem_valid_o, 1'b0);
      chk("rst_inst_rvalid", inst_rvalid_o, 1'b0);
      chk("rst_data_rvalid", data_rvalid_o, 1'b0);
      inst_valid_i = 1'b0;
      mem_rvalid_i = 1'b0;
      rst_i        = 1'b0;
      tick();

      // ---------------- 1: single fetch, response next cycle
      inst_valid_i = 1'b1;
      inst_addr_i  = 64'h0;
      settle();
      chk("t1_mem_valid", mem_valid_o, 1'b1);
      chk("t1_inst_ready", inst_ready_o, 1'b1);
      chk("t1_data_ready", data_ready_o, 1'b0);
      chk("t1_mem_addr", mem_addr_o, 64'h0);
      tick();
      inst_valid_i = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h13;
      settle();
      chk("t1_inst_rvalid", inst_rvalid_o, 1'b1);
      chk("t1_data_rvalid", data_rvalid_o, 1'b0);
      chk("t1_inst_rdata", inst_rdata_o, 64'h13);
      chk("t1_data_rdata", data_rdata_o, 64'h13);
      tick();
      mem_rvalid_i = 1'b0;
      settle();
      chk("t1_idle_mem_valid", mem_valid_o, 1'b0);

      // ---------------- 2: contention, data first then inst
      inst_valid_i = 1'b1;
      inst_addr_i  = 64'h100;
      data_valid_i = 1'b1;
      data_addr_i  = 64'h2000;
      data_wdata_i = 64'hdead_beef_0bad_f00d;
      data_wmask_i = 8'hff;
      settle();
      chk("t2_data_ready", data_ready_o, 1'b1);
      chk("t2_inst_ready0", inst_ready_o, 1'b0);
      chk("t2_addr_data", mem_addr_o, 64'h2000);
      chk("t2_wmask_data", mem_wmask_o, 8'hff);
      chk("t2_wdata_data", mem_wdata_o, 64'hdead_beef_0bad_f00d);
      tick();
      data_valid_i = 1'b0;
      settle();
      chk("t2_inst_ready1", inst_ready_o, 1'b1);
      chk("t2_addr_inst", mem_addr_o, 64'h100);
      chk("t2_wmask_inst", mem_wmask_o, 8'h00);
      tick();
      inst_valid_i = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h22;
      settle();
      chk("t2_resp1_data", data_rvalid_o, 1'b1);
      chk("t2_resp1_inst", inst_rvalid_o, 1'b0);
      tick();
      mem_rdata_i = 64'h11;
      settle();
      chk("t2_resp2_inst", inst_rvalid_o, 1'b1);
      chk("t2_resp2_data", data_rvalid_o, 1'b0);
      tick();
      mem_rvalid_i = 1'b0;

      // ---------------- 3: memory stalls for 3 cycles
      inst_valid_i = 1'b1;
      inst_addr_i  = 64'h300;
      mem_ready_i  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t3_stall_ready", inst_ready_o, 1'b0);
         chk("t3_stall_valid", mem_valid_o, 1'b1);
         chk("t3_stall_addr", mem_addr_o, 64'h300);
         tick();
      end
      mem_ready_i = 1'b1;
      settle();
      chk("t3_accept", inst_ready_o, 1'b1);
      tick();
      inst_valid_i = 1'b0;
      mem_rvalid_i = 1'b1;
      settle();
      chk("t3_resp", inst_rvalid_o, 1'b1);
      tick();
      mem_rvalid_i = 1'b0;

      // ---------------- 4: tracker fills at four outstanding
      inst_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inst_addr_i = 64'h400 + 64'(i * 4);
         settle();
         chk("t4_fill_ready", inst_ready_o, 1'b1);
         tick();
      end
      inst_addr_i = 64'h410;
      settle();
      chk("t4_full_ready", inst_ready_o, 1'b0);
      chk("t4_full_valid", mem_valid_o, 1'b0);
      mem_rvalid_i = 1'b1;
      settle();
      chk("t4_pop_rvalid", inst_rvalid_o, 1'b1);
      chk("t4_pop_still_blocked", inst_ready_o, 1'b0);
      tick();
      mem_rvalid_i = 1'b0;
      settle();
      chk("t4_slot_free_ready", inst_ready_o, 1'b1);
      tick();
      inst_valid_i = 1'b0;
      mem_rvalid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t4_drain_rvalid", inst_rvalid_o, 1'b1);
         tick();
      end
      mem_rvalid_i = 1'b0;
      settle();
      chk("t4_drained_data_rvalid", data_rvalid_o, 1'b0);

      // ---------------- 5: continuous contention for 6 cycles
      // Last handshake was inst, so data wins the first cycle in both builds.
      inst_valid_i = 1'b1;
      inst_addr_i  = 64'h500;
      data_valid_i = 1'b1;
      data_addr_i  = 64'h5000;
      data_wmask_i = 8'h0f;
      prev_data    = 1'b0;
      for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARBITER_RR_EN
         exp_data = ((i % 2) == 0);
`else
         exp_data = 1'b1;
`endif
         mem_rvalid_i = (i != 0);
         settle();
         chk("t5_data_grant", data_ready_o, exp_data);
         chk("t5_inst_grant", inst_ready_o, !exp_data);
         chk("t5_addr", mem_addr_o, exp_data ? 64'h5000 : 64'h500);
         if (i != 0) begin
            chk("t5_route_data", data_rvalid_o, prev_data);
            chk("t5_route_inst", inst_rvalid_o, !prev_data);
         end
         prev_data = exp_data;
         tick();
      end
      inst_valid_i = 1'b0;
      data_valid_i = 1'b0;
      mem_rvalid_i = 1'b1;
      settle();
      chk("t5_last_route_data", data_rvalid_o, prev_data);
      tick();
      mem_rvalid_i = 1'b0;

      // ---------------- 6: reset with two outstanding, stray response dropped
      data_valid_i = 1'b1;
      data_addr_i  = 64'h600;
      settle();
      chk("t6_req1", data_ready_o, 1'b1);
      tick();
      settle();
      chk("t6_req2", data_ready_o, 1'b1);
      tick();
      data_valid_i = 1'b0;
      rst_i        = 1'b1;
      settle();
      chk("t6_rst_mem_valid", mem_valid_o, 1'b0);
      tick();
      rst_i        = 1'b0;
      mem_rvalid_i = 1'b1;
      settle();
      chk("t6_drop_data", data_rvalid_o, 1'b0);
      chk("t6_drop_inst", inst_rvalid_o, 1'b0);
      tick();
      mem_rvalid_i = 1'b0;
      inst_valid_i = 1'b1;
      inst_addr_i  = 64'h700;
      settle();
      chk("t6_post_ready", inst_ready_o, 1'b1);
      tick();
      inst_valid_i = 1'b0;
      mem_rvalid_i = 1'b1;
      settle();
      chk("t6_post_rvalid", inst_rvalid_o, 1'b1);
      tick();
      mem_rvalid_i = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mem_arbiter
